// File: rtl/ledger_pkg.sv
// ---------------------------------------------------------------------------
// ledger_pkg
//
// Definitions shared by the ledger transfer unit and its hash core:
//   - byte offsets of the six 8-bit fields in the 48-bit player image
//     {p1_private, p1_public, p1_money, p2_private, p2_public, p2_money}
//   - transfer status encodings
//   - transfer FSM state enum
//   - number of entries in the hash lookup table
//   - a small helper to read one image byte by field offset
//
// No ports (package).
// ---------------------------------------------------------------------------
package ledger_pkg;

    // Hash lookup table size; the index of every round is reduced modulo this.
    localparam int TABLE_ENTRIES = 36;

    // Field offsets in bytes from the LSB end of the image.
    localparam int P1_PRIVATE_OFS = 5;
    localparam int P1_PUBLIC_OFS  = 4;
    localparam int P1_MONEY_OFS   = 3;
    localparam int P2_PRIVATE_OFS = 2;
    localparam int P2_PUBLIC_OFS  = 1;
    localparam int P2_MONEY_OFS   = 0;

    // Transfer result codes.
    localparam logic [1:0] STATUS_COMMIT   = 2'b00;
    localparam logic [1:0] STATUS_BAD_KEY  = 2'b01;
    localparam logic [1:0] STATUS_NO_FUNDS = 2'b10;
    localparam logic [1:0] STATUS_OVERFLOW = 2'b11;

    // Transfer sequencing.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HASH   = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Extract one 8-bit field of the image given its byte offset.
    function automatic logic [7:0] image_byte(input logic [47:0] image,
                                              input int          ofs);
        return image[8*ofs +: 8];
    endfunction

endpackage

// File: rtl/ledger_hash_core.sv
// ---------------------------------------------------------------------------
// ledger_hash_core
//
// One combinational round of the key hash:
//     h_next = T[(h ^ key ^ round) mod 36]
// where T[k] = random_table[8k+7:8k]. This is the exact function used to
// derive the public keys stored in the player image, so anything that needs
// to (re)compute a public key should iterate this block.
//
// Ports:
//   h            in  8    current hash accumulator
//   key          in  8    key being hashed
//   round        in  4    round number (0 .. rounds-1)
//   random_table in  288  36-byte lookup table
//   h_next       out 8    accumulator after this round
// ---------------------------------------------------------------------------
module ledger_hash_core
    import ledger_pkg::*;
(
    input  logic [7:0]   h,
    input  logic [7:0]   key,
    input  logic [3:0]   round,
    input  logic [287:0] random_table,
    output logic [7:0]   h_next
);

    logic [7:0] mixed;
    logic [7:0] folded;
    logic [5:0] index;
    logic [7:0] table_bytes [TABLE_ENTRIES];

    // Unpack the flat table into an addressable byte array.
    for (genvar k = 0; k < TABLE_ENTRIES; k++) begin : g_unpack
        assign table_bytes[k] = random_table[8*k +: 8];
    end

    assign mixed  = h ^ key ^ {4'b0000, round};

    // The remainder of an 8-bit value by 36 is always below 36, so only the
    // low six bits carry information; the upper two are always zero.
    assign folded = mixed % 8'(TABLE_ENTRIES);
    assign index  = folded[5:0];

    assign h_next = table_bytes[index];

endmodule

// File: rtl/ledger_transfer_unit.sv
// ---------------------------------------------------------------------------
// ledger_transfer_unit
//
// Holds the 48-bit player image and executes one coin transfer at a time
// between player 1 and player 2. The presented key is hashed over
// HASH_ROUNDS table-lookup rounds and compared with the sender's stored
// public key; the balance and overflow rules are then applied and the
// updated image is either committed or the transfer is rejected.
//
// Latency from an accepted start to done is HASH_ROUNDS+2 cycles:
//   cycles 1..HASH_ROUNDS   HASH   (one round per cycle)
//   cycle  HASH_ROUNDS+1    CHECK  (result and new image registered)
//   cycle  HASH_ROUNDS+2    FINISH (done pulse, busy low)
//
// Parameters:
//   HASH_ROUNDS   hash rounds per key, 1..15 (default 4)
//
// Ports:
//   clock         in  1    rising-edge clock
//   reset         in  1    synchronous active-high reset
//   random_table  in  288  hash table, stable while busy
//   load          in  1    pulse: copy memory_in into the image (IDLE only)
//   memory_in     in  48   image to load
//   start         in  1    pulse: request a transfer (IDLE, load low)
//   sender        in  1    0: p1 pays p2, 1: p2 pays p1
//   key_in        in  8    key presented by the sender
//   amount        in  8    coins to move
//   memory_out    out 48   current image
//   busy          out 1    transfer in progress (HASH/CHECK)
//   done          out 1    one-cycle pulse at transfer end
//   status        out 2    result, held until the next accepted start
//
// Optional feature, enabled by defining LEDGER_TXN_LOG_EN:
//   txn_count     out 8    number of committed transfers, wraps at 256
//   last_reject   out 2    most recent non-zero status
// ---------------------------------------------------------------------------
module ledger_transfer_unit
    import ledger_pkg::*;
#(
    parameter int HASH_ROUNDS = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [287:0] random_table,
    input  logic         load,
    input  logic [47:0]  memory_in,
    input  logic         start,
    input  logic         sender,
    input  logic [7:0]   key_in,
    input  logic [7:0]   amount,
    output logic [47:0]  memory_out,
    output logic         busy,
    output logic         done,
    output logic [1:0]   status
`ifdef LEDGER_TXN_LOG_EN
    ,
    output logic [7:0]   txn_count,
    output logic [1:0]   last_reject
`endif
);

    localparam logic [3:0] LAST_ROUND = 4'(HASH_ROUNDS - 1);

    state_e      state;
    logic [47:0] image;
    logic [7:0]  h;
    logic [3:0]  r;
    logic        txn_sender;
    logic [7:0]  txn_key;
    logic [7:0]  txn_amount;
    logic [1:0]  result;

    logic [7:0]  h_next;
    logic [7:0]  sender_public;
    logic [7:0]  sender_money;
    logic [7:0]  receiver_money;
    logic [8:0]  receiver_sum;
    logic [7:0]  sender_remaining;
    logic [1:0]  check_status;
    logic [47:0] next_image;

    ledger_hash_core u_hash_core (
        .h            (h),
        .key          (txn_key),
        .round        (r),
        .random_table (random_table),
        .h_next       (h_next)
    );

    // Select the sender/receiver fields according to the captured direction
    // and evaluate the rules in priority order. The receiver sum is kept one
    // bit wider so that its carry is the overflow flag.
    always_comb begin
        sender_public  = image_byte(image, P1_PUBLIC_OFS);
        sender_money   = image_byte(image, P1_MONEY_OFS);
        receiver_money = image_byte(image, P2_MONEY_OFS);
        if (txn_sender) begin
            sender_public  = image_byte(image, P2_PUBLIC_OFS);
            sender_money   = image_byte(image, P2_MONEY_OFS);
            receiver_money = image_byte(image, P1_MONEY_OFS);
        end

        receiver_sum     = {1'b0, receiver_money} + {1'b0, txn_amount};
        sender_remaining = sender_money - txn_amount;

        if (h != sender_public) begin
            check_status = STATUS_BAD_KEY;
        end else if (txn_amount > sender_money) begin
            check_status = STATUS_NO_FUNDS;
        end else if (receiver_sum[8]) begin
            check_status = STATUS_OVERFLOW;
        end else begin
            check_status = STATUS_COMMIT;
        end
    end

    // Committed image: only the two money bytes ever change.
    always_comb begin
        next_image = image;
        if (txn_sender) begin
            next_image[8*P2_MONEY_OFS +: 8] = sender_remaining;
            next_image[8*P1_MONEY_OFS +: 8] = receiver_sum[7:0];
        end else begin
            next_image[8*P1_MONEY_OFS +: 8] = sender_remaining;
            next_image[8*P2_MONEY_OFS +: 8] = receiver_sum[7:0];
        end
    end

    // Transfer sequencer. Load and start are only honoured in IDLE, with
    // load taking priority, so nothing can disturb the image or operands
    // while a transfer is in flight. The image is written only in CHECK and
    // only on a commit, so a reset before then leaves no partial update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            image      <= '0;
            h          <= '0;
            r          <= '0;
            txn_sender <= 1'b0;
            txn_key    <= '0;
            txn_amount <= '0;
            result     <= STATUS_COMMIT;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        image <= memory_in;
                    end else if (start) begin
                        txn_sender <= sender;
                        txn_key    <= key_in;
                        txn_amount <= amount;
                        h          <= 8'h00;
                        r          <= 4'd0;
                        state      <= HASH;
                    end
                end
                HASH: begin
                    h <= h_next;
                    r <= r + 4'd1;
                    if (r == LAST_ROUND) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    result <= check_status;
                    if (check_status == STATUS_COMMIT) begin
                        image <= next_image;
                    end
                    state <= FINISH;
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign memory_out = image;
    assign busy       = (state == HASH) || (state == CHECK);
    assign done       = (state == FINISH);
    assign status     = result;

`ifdef LEDGER_TXN_LOG_EN
    // Transaction log: both values are updated alongside the registered
    // status, i.e. once per transfer at the end of CHECK.
    always_ff @(posedge clock) begin
        if (reset) begin
            txn_count   <= '0;
            last_reject <= '0;
        end else if (state == CHECK) begin
            if (check_status == STATUS_COMMIT) begin
                txn_count <= txn_count + 8'd1;
            end else begin
                last_reject <= check_status;
            end
        end
    end
`else
    // Transaction log not built: no counter or reject register exists.
`endif

endmodule

// File: tb/tb_ledger_transfer_unit.sv
// ---------------------------------------------------------------------------
// tb_ledger_transfer_unit
//
// Self-checking bench for ledger_transfer_unit. Directed scenarios from the
// transfer rules plus randomized transfers checked against a behavioural
// model of the ledger (hash by table walk, balance rules by integer
// arithmetic). Build with LEDGER_TXN_LOG_EN defined to also cover the log.
// ---------------------------------------------------------------------------
module tb_ledger_transfer_unit;

    localparam int HR = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [287:0] random_table;
    logic         load;
    logic [47:0]  memory_in;
    logic         start;
    logic         sender;
    logic [7:0]   key_in;
    logic [7:0]   amount;
    logic [47:0]  memory_out;
    logic         busy;
    logic         done;
    logic [1:0]   status;
`ifdef LEDGER_TXN_LOG_EN
    logic [7:0]   txn_count;
    logic [1:0]   last_reject;
`endif

    int checks   = 0;
    int failures = 0;

    int          tbl [36];
    logic [47:0] model_img;

    always #5 clock = ~clock;

    ledger_transfer_unit #(.HASH_ROUNDS(HR)) dut (
        .clock        (clock),
        .reset        (reset),
        .random_table (random_table),
        .load         (load),
        .memory_in    (memory_in),
        .start        (start),
        .sender       (sender),
        .key_in       (key_in),
        .amount       (amount),
        .memory_out   (memory_out),
        .busy         (busy),
        .done         (done),
        .status       (status)
`ifdef LEDGER_TXN_LOG_EN
        ,
        .txn_count    (txn_count),
        .last_reject  (last_reject)
`endif
    );

    // Reference hash: walk the table HR times starting from zero.
    function automatic logic [7:0] model_hash(input logic [7:0] k);
        int hv = 0;
        for (int rr = 0; rr < HR; rr++) begin
            hv = tbl[(hv ^ int'(k) ^ rr) % 36];
        end
        return 8'(hv);
    endfunction

    function automatic logic [47:0] make_image(input logic [7:0] priv1, input int money1,
                                               input logic [7:0] priv2, input int money2);
        return {priv1, model_hash(priv1), 8'(money1), priv2, model_hash(priv2), 8'(money2)};
    endfunction

    // Reference ledger rules on plain integers.
    function automatic void model_transfer(input logic [47:0] img, input logic s,
                                           input logic [7:0] k, input logic [7:0] a,
                                           output logic [47:0] nimg, output logic [1:0] st);
        int m1, m2, amt, pay_bal, recv_bal;
        logic [7:0] pub;
        m1  = int'(img[31:24]);
        m2  = int'(img[7:0]);
        amt = int'(a);
        pub = s ? img[15:8] : img[39:32];
        pay_bal  = s ? m2 : m1;
        recv_bal = s ? m1 : m2;
        nimg = img;
        if (model_hash(k) != pub)        st = 2'd1;
        else if (amt > pay_bal)          st = 2'd2;
        else if (recv_bal + amt > 255)   st = 2'd3;
        else begin
            st = 2'd0;
            if (s) begin m2 -= amt; m1 += amt; end
            else   begin m1 -= amt; m2 += amt; end
            nimg[31:24] = 8'(m1);
            nimg[7:0]   = 8'(m2);
        end
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_img = '0;
    endtask

    task automatic do_load(input logic [47:0] img);
        @(negedge clock);
        load = 1'b1;
        memory_in = img;
        @(negedge clock);
        load = 1'b0;
        model_img = img;
    endtask

    // Issue one start and wait (bounded) for done. lat counts cycles from
    // the start edge; busy_ok records whether busy was high throughout and
    // low with done. Returns one cycle after done so the unit is in IDLE.
    task automatic do_transfer(input logic s, input logic [7:0] k, input logic [7:0] a,
                               output int lat, output logic [1:0] st, output logic busy_ok);
        @(negedge clock);
        sender = s; key_in = k; amount = a; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clock);
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        st = status;
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (memory_out !== 48'h0) begin failures++; $display("[TB] FAIL reset_image: got %h expected %h", memory_out, 48'h0); end
        if (busy !== 1'b0)        begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)        begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        if (status !== 2'b00)     begin failures++; $display("[TB] FAIL reset_status: got %b expected 00", status); end
    endtask

    task automatic test_load();
        logic [47:0] img;
        img = make_image(8'h75, 100, 8'h1B, 100);
        @(negedge clock);
        load = 1'b1; memory_in = img;
        @(negedge clock);
        load = 1'b0;
        model_img = img;
        checks++;
        if (memory_out !== img) begin failures++; $display("[TB] FAIL load_image: got %h expected %h", memory_out, img); end
    endtask

    task automatic test_commit();
        int lat; logic [1:0] st; logic bok;
        do_load(make_image(8'h75, 100, 8'h1B, 100));
        do_transfer(1'b0, 8'h75, 8'd30, lat, st, bok);
        checks += 6;
        if (lat !== HR + 2) begin failures++; $display("[TB] FAIL commit_latency: got %0d expected %0d", lat, HR + 2); end
        if (bok !== 1'b1)   begin failures++; $display("[TB] FAIL commit_busy: got %b expected 1", bok); end
        if (st !== 2'b00)   begin failures++; $display("[TB] FAIL commit_status: got %b expected 00", st); end
        if (memory_out[31:24] !== 8'd70)  begin failures++; $display("[TB] FAIL commit_p1_money: got %0d expected 70", memory_out[31:24]); end
        if (memory_out[7:0] !== 8'd130)   begin failures++; $display("[TB] FAIL commit_p2_money: got %0d expected 130", memory_out[7:0]); end
        if ({memory_out[47:32], memory_out[23:8]} !== {model_img[47:32], model_img[23:8]}) begin
            failures++; $display("[TB] FAIL commit_keys: got %h expected %h", memory_out, model_img);
        end
    endtask

    task automatic test_bad_key();
        int lat; logic [1:0] st; logic bok;
        logic [47:0] img;
        img = make_image(8'h75, 100, 8'h1B, 100);
        do_load(img);
        do_transfer(1'b0, 8'h74, 8'd30, lat, st, bok);
        checks += 3;
        if (lat !== HR + 2)     begin failures++; $display("[TB] FAIL badkey_latency: got %0d expected %0d", lat, HR + 2); end
        if (st !== 2'b01)       begin failures++; $display("[TB] FAIL badkey_status: got %b expected 01", st); end
        if (memory_out !== img) begin failures++; $display("[TB] FAIL badkey_image: got %h expected %h", memory_out, img); end
    endtask

    task automatic test_funds_boundary();
        int lat; logic [1:0] st; logic bok;
        logic [47:0] img;
        img = make_image(8'h75, 100, 8'h1B, 100);
        do_load(img);
        do_transfer(1'b1, 8'h1B, 8'd101, lat, st, bok);
        checks += 2;
        if (st !== 2'b10)       begin failures++; $display("[TB] FAIL funds_101_status: got %b expected 10", st); end
        if (memory_out !== img) begin failures++; $display("[TB] FAIL funds_101_image: got %h expected %h", memory_out, img); end
        do_transfer(1'b1, 8'h1B, 8'd100, lat, st, bok);
        checks += 3;
        if (st !== 2'b00)                begin failures++; $display("[TB] FAIL funds_100_status: got %b expected 00", st); end
        if (memory_out[7:0] !== 8'd0)    begin failures++; $display("[TB] FAIL funds_100_p2_money: got %0d expected 0", memory_out[7:0]); end
        if (memory_out[31:24] !== 8'd200) begin failures++; $display("[TB] FAIL funds_100_p1_money: got %0d expected 200", memory_out[31:24]); end
    endtask

    task automatic test_overflow_and_zero();
        int lat; logic [1:0] st; logic bok;
        logic [47:0] img;
        img = make_image(8'h75, 100, 8'h1B, 200);
        do_load(img);
        do_transfer(1'b0, 8'h75, 8'd60, lat, st, bok);
        checks += 2;
        if (st !== 2'b11)       begin failures++; $display("[TB] FAIL overflow_status: got %b expected 11", st); end
        if (memory_out !== img) begin failures++; $display("[TB] FAIL overflow_image: got %h expected %h", memory_out, img); end
        // Exactly 255 after the transfer is still legal.
        do_transfer(1'b0, 8'h75, 8'd55, lat, st, bok);
        checks += 2;
        if (st !== 2'b00)             begin failures++; $display("[TB] FAIL sum255_status: got %b expected 00", st); end
        if (memory_out[7:0] !== 8'd255) begin failures++; $display("[TB] FAIL sum255_p2_money: got %0d expected 255", memory_out[7:0]); end
        img = memory_out;
        do_transfer(1'b1, 8'h1B, 8'd0, lat, st, bok);
        checks += 2;
        if (st !== 2'b00)       begin failures++; $display("[TB] FAIL zero_amount_status: got %b expected 00", st); end
        if (memory_out !== img) begin failures++; $display("[TB] FAIL zero_amount_image: got %h expected %h", memory_out, img); end
    endtask

    task automatic test_reset_midflight();
        int done_seen = 0;
        do_load(make_image(8'h75, 100, 8'h1B, 100));
        @(negedge clock);
        sender = 1'b0; key_in = 8'h75; amount = 8'd30; start = 1'b1;
        @(negedge clock);               // cycle 1
        start = 1'b0;
        @(negedge clock);               // cycle 2
        @(negedge clock);               // cycle 3
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_img = '0;
        checks += 4;
        if (busy !== 1'b0)         begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)         begin failures++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
        if (memory_out !== 48'h0)  begin failures++; $display("[TB] FAIL midreset_image: got %h expected 0", memory_out); end
        if (status !== 2'b00)      begin failures++; $display("[TB] FAIL midreset_status: got %b expected 00", status); end
        for (int i = 0; i < 2 * HR + 6; i++) begin
            @(negedge clock);
            if (done === 1'b1) done_seen++;
        end
        checks += 2;
        if (done_seen !== 0)       begin failures++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", done_seen); end
        if (memory_out !== 48'h0)  begin failures++; $display("[TB] FAIL midreset_no_commit: got %h expected 0", memory_out); end
    endtask

    task automatic test_back_to_back();
        int done_seen = 0;
        logic [47:0] exp_img;
        logic [1:0]  exp_st;
        logic [47:0] other;
        do_load(make_image(8'h75, 100, 8'h1B, 100));
        model_transfer(model_img, 1'b0, 8'h75, 8'd30, exp_img, exp_st);
        other = make_image(8'h11, 5, 8'h22, 6);
        @(negedge clock);
        sender = 1'b0; key_in = 8'h75; amount = 8'd30; start = 1'b1;
        @(negedge clock);               // cycle 1
        start = 1'b0;
        @(negedge clock);               // cycle 2: extra start and load while busy
        sender = 1'b1; key_in = 8'h1B; amount = 8'd1; start = 1'b1;
        load = 1'b1; memory_in = other;
        @(negedge clock);
        start = 1'b0; load = 1'b0;
        for (int i = 0; i < 3 * (HR + 3); i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clock);
        end
        checks += 3;
        if (done_seen !== 1)       begin failures++; $display("[TB] FAIL busy_start_done_count: got %0d expected 1", done_seen); end
        if (status !== exp_st)     begin failures++; $display("[TB] FAIL busy_start_status: got %b expected %b", status, exp_st); end
        if (memory_out !== exp_img) begin failures++; $display("[TB] FAIL busy_load_image: got %h expected %h", memory_out, exp_img); end
        model_img = exp_img;
    endtask

    task automatic test_load_start_same_cycle();
        logic [47:0] img;
        int busy_seen = 0;
        img = make_image(8'h75, 40, 8'h1B, 50);
        @(negedge clock);
        load = 1'b1; memory_in = img;
        start = 1'b1; sender = 1'b0; key_in = 8'h75; amount = 8'd10;
        @(negedge clock);
        load = 1'b0; start = 1'b0;
        model_img = img;
        for (int i = 0; i < HR + 3; i++) begin
            if (busy === 1'b1 || done === 1'b1) busy_seen++;
            @(negedge clock);
        end
        checks += 2;
        if (memory_out !== img) begin failures++; $display("[TB] FAIL load_start_image: got %h expected %h", memory_out, img); end
        if (busy_seen !== 0)    begin failures++; $display("[TB] FAIL load_start_dropped: got %0d busy cycles expected 0", busy_seen); end
    endtask

    task automatic test_random();
        int lat; logic [1:0] st; logic bok;
        logic [47:0] exp_img;
        logic [1:0]  exp_st;
        logic        s;
        logic [7:0]  k, a, p1, p2;
        for (int i = 0; i < 30; i++) begin
            if (i % 6 == 0) begin
                p1 = 8'($urandom); p2 = 8'($urandom);
                do_load(make_image(p1, int'($urandom_range(0, 255)), p2, int'($urandom_range(0, 255))));
            end
            s = 1'($urandom);
            k = s ? model_img[23:16] : model_img[47:40];
            if ($urandom_range(0, 3) == 0) k = 8'($urandom);
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            model_transfer(model_img, s, k, a, exp_img, exp_st);
            do_transfer(s, k, a, lat, st, bok);
            checks += 4;
            if (lat !== HR + 2)          begin failures++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, lat, HR + 2); end
            if (bok !== 1'b1)            begin failures++; $display("[TB] FAIL rand%0d_busy: got %b expected 1", i, bok); end
            if (st !== exp_st)           begin failures++; $display("[TB] FAIL rand%0d_status: got %b expected %b", i, st, exp_st); end
            if (memory_out !== exp_img)  begin failures++; $display("[TB] FAIL rand%0d_image: got %h expected %h", i, memory_out, exp_img); end
            model_img = exp_img;
        end
    endtask

`ifdef LEDGER_TXN_LOG_EN
    task automatic test_txn_log();
        int lat; logic [1:0] st; logic bok;
        do_reset();
        checks += 2;
        if (txn_count !== 8'd0)   begin failures++; $display("[TB] FAIL log_reset_count: got %0d expected 0", txn_count); end
        if (last_reject !== 2'b00) begin failures++; $display("[TB] FAIL log_reset_reject: got %b expected 00", last_reject); end
        do_load(make_image(8'h75, 100, 8'h1B, 100));
        do_transfer(1'b0, 8'h75, 8'd1, lat, st, bok);
        do_transfer(1'b0, 8'h74, 8'd1, lat, st, bok);
        do_transfer(1'b1, 8'h1B, 8'd2, lat, st, bok);
        do_transfer(1'b0, 8'h75, 8'd3, lat, st, bok);
        checks += 2;
        if (txn_count !== 8'd3)    begin failures++; $display("[TB] FAIL log_count: got %0d expected 3", txn_count); end
        if (last_reject !== 2'b01) begin failures++; $display("[TB] FAIL log_reject: got %b expected 01", last_reject); end
    endtask
`endif

    // Distinct random table; retried until the directed bad key 0x74
    // genuinely hashes differently from the good key 0x75.
    task automatic build_table();
        int tries = 0;
        bit dup;
        do begin
            for (int i = 0; i < 36; i++) begin
                do begin
                    tbl[i] = int'($urandom_range(0, 255));
                    dup = 1'b0;
                    for (int j = 0; j < i; j++) if (tbl[j] == tbl[i]) dup = 1'b1;
                end while (dup);
            end
            tries++;
        end while (model_hash(8'h74) == model_hash(8'h75) && tries < 100);
        for (int i = 0; i < 36; i++) random_table[8*i +: 8] = 8'(tbl[i]);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; sender = 1'b0;
        key_in = '0; amount = '0; memory_in = '0; random_table = '0;
        model_img = '0;
        build_table();
        test_reset();
        test_load();
        test_commit();
        test_bad_key();
        test_funds_boundary();
        test_overflow_and_zero();
        test_reset_midflight();
        test_back_to_back();
        test_load_start_same_cycle();
        test_random();
`ifdef LEDGER_TXN_LOG_EN
        test_txn_log();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
